// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parameterised synchronous FIFO.
//   clog2        - ceiling log2, usable in constant expressions
//   ptr_w        - pointer width (address bits plus a wrap bit)
//   def_af_thresh - default almost-full threshold for a given depth
//   DEF_*        - default configuration constants
package fifo_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_DEPTH     = 16;
   localparam int unsigned DEF_AE_THRESH = 2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

   function automatic int unsigned def_af_thresh(input int unsigned depth);
      return depth - 2;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH register-array storage, no reset.
//   clk        - write clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write address
//   i_wr_data  - write data
//   i_rd_addr  - asynchronous read address
//   o_rd_data  - asynchronous read data
module fifo_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = 4
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with fill count, almost flags,
// synchronous flush and sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise dout is a registered read with one cycle of latency.
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous clear of contents (overrides wr_en/rd_en)
//   wr_en, din           - write request and data
//   rd_en, dout          - read request and data
//   full, empty          - count == DEPTH / count == 0
//   almost_full/_empty   - count >= AF_THRESH / count <= AE_THRESH
//   count                - occupancy 0..DEPTH
//   err_clr              - clears overflow/underflow (a same-cycle set wins)
//   overflow, underflow  - sticky rejected-write / rejected-read flags
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AF_THRESH = def_af_thresh(DEPTH),
   parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       din,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       dout,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [clog2(DEPTH):0]   count,
   input  logic                    err_clr,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned PW = ptr_w(DEPTH);

   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
   localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [PW-1:0]     w_count;
   logic              w_empty, w_full;
   logic              w_rd_acc, w_wr_acc;
   logic              w_ovf_set, w_unf_set;
   logic              r_overflow, r_underflow;
   logic              w_overflow_nxt, w_underflow_nxt;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] r_dout;

   // Occupancy is the pointer difference; the wrap bit disambiguates full from empty.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_count == '0);
   assign w_full  = (w_count == DEPTH_L);

   assign count        = w_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (w_count >= AF_L);
   assign almost_empty = (w_count <= AE_L);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // A full FIFO still takes a write when a read frees the head slot in the same cycle.
   always_comb begin
      w_rd_acc  = 1'b0;
      w_wr_acc  = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (!flush) begin
         w_rd_acc  = rd_en && !w_empty;
         w_wr_acc  = wr_en && (!w_full || rd_en);
         w_ovf_set = wr_en && !w_wr_acc;
         w_unf_set = rd_en && !w_rd_acc;
      end
   end

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
         if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
      end
   end

   always_comb begin
      w_overflow_nxt  = r_overflow;
      w_underflow_nxt = r_underflow;
      if (err_clr) begin
         w_overflow_nxt  = 1'b0;
         w_underflow_nxt = 1'b0;
      end
      if (w_ovf_set) w_overflow_nxt  = 1'b1;
      if (w_unf_set) w_underflow_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_overflow  <= w_overflow_nxt;
         r_underflow <= w_underflow_nxt;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (din),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown directly; r_dout remembers it so dout holds while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (!w_empty) begin
         r_dout <= w_rd_data;
      end
   end

   assign dout = w_empty ? r_dout : w_rd_data;
`else
   // Sampled before the write lands, so full+read+write returns the old head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (w_rd_acc) begin
         r_dout <= w_rd_data;
      end
   end

   assign dout = r_dout;
`endif

endmodule
